// File: rtl/bbox_detect.sv
// bbox_detect: per-frame bounding box of a 1-bit colour-threshold mask stream.
// Accumulates min/max column and line of qualified mask pixels over one frame
// and publishes the box once per frame, two clocks after the vsync rising edge.
// Optional build macro BBOX_SMOOTH_EN: averages each new valid box with the
// previous valid box instead of loading it directly.
module bbox_detect #(
    parameter int CNT_W      = 12,
    parameter int MIN_PIXELS = 64,
    parameter int PIX_W      = 21
) (
    input  logic             pixelclk,
    input  logic             reset_n,
    input  logic             i_mask,
    input  logic             i_hsync,
    input  logic             i_vsync,
    input  logic             i_de,
    output logic [CNT_W-1:0] hcount_l,
    output logic [CNT_W-1:0] hcount_r,
    output logic [CNT_W-1:0] vcount_l,
    output logic [CNT_W-1:0] vcount_r,
    output logic             o_valid,
    output logic             o_frame_done
);

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_ACCUM,
        ST_LATCH
    } state_t;

    state_t state, state_nxt;

    logic             vs_d;
    logic             de_d;
    logic             vs_rise;
    logic             de_fall;
    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] vcnt;
    logic [CNT_W-1:0] min_h, max_h, min_v, max_v;
    logic [PIX_W-1:0] pix_cnt;
    logic             acc_clr;
    logic             acc_en;
    logic             latch_en;
    logic             frame_ok;

    // hsync carries no information for this block; kept on the port for alignment
    logic unused_hsync;
    assign unused_hsync = i_hsync;

    assign vs_rise  = i_vsync & ~vs_d;
    assign de_fall  = de_d & ~i_de;
    assign frame_ok = (pix_cnt >= PIX_W'(MIN_PIXELS));

    // Edge-detect registers for vsync and data enable
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            vs_d <= 1'b0;
            de_d <= 1'b0;
        end else begin
            vs_d <= i_vsync;
            de_d <= i_de;
        end
    end

    // Column counter: holds the column of the current de-high cycle, 0 at line start
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            hcnt <= '0;
        end else if (i_de) begin
            if (hcnt != '1)
                hcnt <= hcnt + CNT_W'(1);
        end else begin
            hcnt <= '0;
        end
    end

    // Line counter: advances at each de falling edge, restarts at frame boundary
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            vcnt <= '0;
        end else if (vs_rise) begin
            vcnt <= '0;
        end else if (de_fall && vcnt != '1) begin
            vcnt <= vcnt + CNT_W'(1);
        end
    end

    // FSM state register
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n)
            state <= ST_WAIT;
        else
            state <= state_nxt;
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_WAIT:  if (vs_rise) state_nxt = ST_ACCUM;
            ST_ACCUM: if (vs_rise) state_nxt = ST_LATCH;
            ST_LATCH: state_nxt = ST_ACCUM;
            default:  state_nxt = ST_WAIT;
        endcase
    end

    // FSM output decode
    always_comb begin
        acc_clr  = 1'b0;
        acc_en   = 1'b0;
        latch_en = 1'b0;
        unique case (state)
            ST_WAIT:  acc_clr = vs_rise;
            ST_ACCUM: acc_en  = i_de & i_mask;
            ST_LATCH: begin
                acc_clr  = 1'b1;
                latch_en = 1'b1;
            end
            default: ;
        endcase
    end

    // Box accumulators and saturating mask-pixel count
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            min_h   <= '1;
            max_h   <= '0;
            min_v   <= '1;
            max_v   <= '0;
            pix_cnt <= '0;
        end else if (acc_clr) begin
            min_h   <= '1;
            max_h   <= '0;
            min_v   <= '1;
            max_v   <= '0;
            pix_cnt <= '0;
        end else if (acc_en) begin
            if (hcnt < min_h) min_h <= hcnt;
            if (hcnt > max_h) max_h <= hcnt;
            if (vcnt < min_v) min_v <= vcnt;
            if (vcnt > max_v) max_v <= vcnt;
            if (pix_cnt != '1)
                pix_cnt <= pix_cnt + PIX_W'(1);
        end
    end

`ifdef BBOX_SMOOTH_EN
    function automatic logic [CNT_W-1:0] avg2(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_W:1];
    endfunction
`endif

    // Output registers: update only in the latch cycle, held for the whole next frame
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            hcount_l     <= '0;
            hcount_r     <= '0;
            vcount_l     <= '0;
            vcount_r     <= '0;
            o_valid      <= 1'b0;
            o_frame_done <= 1'b0;
        end else begin
            o_frame_done <= latch_en;
            if (latch_en) begin
                if (frame_ok) begin
`ifdef BBOX_SMOOTH_EN
                    if (o_valid) begin
                        hcount_l <= avg2(hcount_l, min_h);
                        hcount_r <= avg2(hcount_r, max_h);
                        vcount_l <= avg2(vcount_l, min_v);
                        vcount_r <= avg2(vcount_r, max_v);
                    end else begin
                        hcount_l <= min_h;
                        hcount_r <= max_h;
                        vcount_l <= min_v;
                        vcount_r <= max_v;
                    end
`else
                    hcount_l <= min_h;
                    hcount_r <= max_h;
                    vcount_l <= min_v;
                    vcount_r <= max_v;
`endif
                    o_valid <= 1'b1;
                end else begin
                    hcount_l <= '0;
                    hcount_r <= '0;
                    vcount_l <= '0;
                    vcount_r <= '0;
                    o_valid  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_bbox_detect.sv
// tb_bbox_detect: directed self-checking bench for bbox_detect.
// Inputs change on the falling clock edge; outputs are sampled on the falling edge.
module tb_bbox_detect;

    localparam int CNT_W = 12;

    logic             pixelclk;
    logic             reset_n;
    logic             i_mask;
    logic             i_hsync;
    logic             i_vsync;
    logic             i_de;
    logic [CNT_W-1:0] hcount_l;
    logic [CNT_W-1:0] hcount_r;
    logic [CNT_W-1:0] vcount_l;
    logic [CNT_W-1:0] vcount_r;
    logic             o_valid;
    logic             o_frame_done;

    int checks = 0;
    int errors = 0;

    bbox_detect #(
        .CNT_W      (CNT_W),
        .MIN_PIXELS (64),
        .PIX_W      (21)
    ) dut (
        .pixelclk     (pixelclk),
        .reset_n      (reset_n),
        .i_mask       (i_mask),
        .i_hsync      (i_hsync),
        .i_vsync      (i_vsync),
        .i_de         (i_de),
        .hcount_l     (hcount_l),
        .hcount_r     (hcount_r),
        .vcount_l     (vcount_l),
        .vcount_r     (vcount_r),
        .o_valid      (o_valid),
        .o_frame_done (o_frame_done)
    );

    initial pixelclk = 1'b0;
    always #5 pixelclk = ~pixelclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input int el, input int er,
                                 input int evl, input int evr, input int ev);
        check({tag, ".hcount_l"}, 32'(hcount_l), el);
        check({tag, ".hcount_r"}, 32'(hcount_r), er);
        check({tag, ".vcount_l"}, 32'(vcount_l), evl);
        check({tag, ".vcount_r"}, 32'(vcount_r), evr);
        check({tag, ".o_valid"},  32'(o_valid),  ev);
    endtask

    // One active line: width de-high cycles, mask on columns lo..hi, then blanking
    task automatic drive_line(input int width, input int lo, input int hi);
        for (int c = 0; c < width; c++) begin
            i_de   = 1'b1;
            i_mask = (c >= lo && c <= hi);
            @(negedge pixelclk);
        end
        i_de    = 1'b0;
        i_mask  = 1'b0;
        i_hsync = 1'b1;
        repeat (2) @(negedge pixelclk);
        i_hsync = 1'b0;
        repeat (2) @(negedge pixelclk);
    endtask

    task automatic drive_lines(input int n, input int width, input int lo, input int hi);
        for (int l = 0; l < n; l++) drive_line(width, lo, hi);
    endtask

    // Frame boundary: vsync high 5 cycles, count frame_done pulses in a bounded window
    task automatic end_frame(input string tag, input int exp_pulses,
                             input int el, input int er, input int evl, input int evr,
                             input int ev);
        int pulses;
        int first;
        pulses  = 0;
        first   = -1;
        i_vsync = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            if (i == 6) i_vsync = 1'b0;
            @(negedge pixelclk);
            if (o_frame_done === 1'b1) begin
                pulses++;
                if (first < 0) first = i;
            end
        end
        check({tag, ".pulses"}, pulses, exp_pulses);
        if (exp_pulses > 0)
            check({tag, ".latency"}, first, 2);
        check_outputs(tag, el, er, evl, evr, ev);
    endtask

    initial begin
        reset_n = 1'b0;
        i_mask  = 1'b0;
        i_hsync = 1'b0;
        i_vsync = 1'b0;
        i_de    = 1'b0;
        repeat (3) @(negedge pixelclk);
        check_outputs("reset", 0, 0, 0, 0, 0);
        check("reset.frame_done", 32'(o_frame_done), 0);
        reset_n = 1'b1;
        @(negedge pixelclk);

        // Partial first frame is discarded: no pulse at the first vsync
        drive_line(70, 0, 69);
        end_frame("first_frame", 0, 0, 0, 0, 0, 0);

        // 8x8 block at cols 100..107, lines 50..57
        drive_lines(50, 1, 1, 0);
        drive_lines(8, 110, 100, 107);
        end_frame("block8x8", 1, 100, 107, 50, 57, 1);

        // Outputs hold mid-frame, then reset mid-frame clears everything
        drive_lines(3, 120, 0, 119);
        check_outputs("hold", 100, 107, 50, 57, 1);
        reset_n = 1'b0;
        #1;
        check_outputs("async_reset", 0, 0, 0, 0, 0);
        repeat (2) @(negedge pixelclk);
        reset_n = 1'b1;
        @(negedge pixelclk);
        drive_line(80, 0, 79);
        end_frame("post_reset", 0, 0, 0, 0, 0, 0);

        // 63 pixels: below threshold, pulse still given
        drive_line(63, 0, 62);
        end_frame("px63", 1, 0, 0, 0, 0, 0);

        // Two consecutive valid frames, l=100 then l=200
        drive_line(164, 100, 163);
        end_frame("frameA", 1, 100, 163, 0, 0, 1);
        drive_line(264, 200, 263);
`ifdef BBOX_SMOOTH_EN
        end_frame("frameB", 1, 150, 213, 0, 0, 1);
`else
        end_frame("frameB", 1, 200, 263, 0, 0, 1);
`endif

        // Empty frame, then exactly 64 pixels on one line
        end_frame("empty1", 1, 0, 0, 0, 0, 0);
        drive_line(64, 0, 63);
        end_frame("px64", 1, 0, 63, 0, 0, 1);
        end_frame("empty2", 1, 0, 0, 0, 0, 0);

        // Two disjoint blobs: 32x2 at (10,10) and one pixel at (600,400)
        drive_lines(10, 1, 1, 0);
        drive_lines(2, 42, 10, 41);
        drive_lines(388, 1, 1, 0);
        drive_line(601, 600, 600);
        end_frame("blobs", 1, 10, 600, 10, 400, 1);
        end_frame("empty3", 1, 0, 0, 0, 0, 0);

        // Frame corners of 1280x720: first pixels of line 0, last pixel of line 719
        drive_line(64, 0, 63);
        drive_lines(718, 1, 1, 0);
        drive_line(1280, 1279, 1279);
        end_frame("corners", 1, 0, 1279, 0, 719, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
